// File: rtl/ring_sequence_monitor.sv
// Run-time integrity checker for a one-hot ring counter: verifies one-hot left rotation,
// counts revolutions and flags illegal states. Define RING_MON_ERRCNT_EN to add err_count.
module ring_sequence_monitor #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned REV_W = 8
`ifdef RING_MON_ERRCNT_EN
  ,
  parameter int unsigned ERR_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] ring_q,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic             err_pulse,
  output logic             rev_pulse,
`ifdef RING_MON_ERRCNT_EN
  output logic [ERR_W-1:0] err_count,
`endif
  output logic [REV_W-1:0] rev_count
);

  typedef enum logic [1:0] {StIdle, StLocked, StError} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               err_pulse_q, err_pulse_d;
  logic               rev_pulse_q, rev_pulse_d;
  logic [REV_W-1:0]   rev_count_q, rev_count_d;

  logic               ring_onehot;
  logic [WIDTH-1:0]   prev_rot;

  assign ring_onehot = (ring_q != '0) && ((ring_q & (ring_q - WIDTH'(1))) == '0);
  assign prev_rot    = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    err_d       = err_q;
    err_pulse_d = 1'b0;
    rev_pulse_d = 1'b0;
    rev_count_d = rev_count_q;
    unique case (state_q)
      StIdle: begin
        // Non-one-hot here is tolerated: the counter may still be held in reset.
        if (en && ring_onehot) begin
          state_d = StLocked;
          prev_d  = ring_q;
        end
      end
      StLocked: begin
        if (en) begin
          if (ring_q == prev_rot) begin
            prev_d = ring_q;
            if (prev_q[WIDTH-1] && ring_q[0]) begin
              rev_count_d = rev_count_q + REV_W'(1);
              rev_pulse_d = 1'b1;
            end
          end else begin
            state_d     = StError;
            err_d       = 1'b1;
            err_pulse_d = 1'b1;
          end
        end
      end
      StError: begin
        if (clr_err) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    locked_d = (state_d == StLocked);
  end

`ifdef RING_MON_ERRCNT_EN
  logic [ERR_W-1:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_pulse_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      prev_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      rev_pulse_q <= 1'b0;
      rev_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
      rev_pulse_q <= rev_pulse_d;
      rev_count_q <= rev_count_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_pulse = err_pulse_q;
  assign rev_pulse = rev_pulse_q;
  assign rev_count = rev_count_q;

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Directed self-checking bench for ring_sequence_monitor (WIDTH=3, REV_W=8).
module tb_ring_sequence_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] ring_q = 3'b000;
  logic       clr_err = 1'b0;
  logic       locked, err, err_pulse, rev_pulse;
  logic [7:0] rev_count;
`ifdef RING_MON_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int errors = 0;
  int checks = 0;

  ring_sequence_monitor #(.WIDTH(3), .REV_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ring_q    (ring_q),
    .clr_err   (clr_err),
    .locked    (locked),
    .err       (err),
    .err_pulse (err_pulse),
    .rev_pulse (rev_pulse),
`ifdef RING_MON_ERRCNT_EN
    .err_count (err_count),
`endif
    .rev_count (rev_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic e, input logic [2:0] r, input logic c);
    en = e; ring_q = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 3'b001, 1'b0);
    step(1'b1, 3'b010, 1'b0);
    checks++;
    if ({locked, err, err_pulse, rev_pulse} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {locked, err, err_pulse, rev_pulse});
    end
    checks++;
    if (rev_count !== 8'd0) begin
      errors++; $display("FAIL reset_rev_count: got %0d want 0", rev_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_and_rev();
    step(1'b1, 3'b001, 1'b0);
    checks++;
    if (locked !== 1'b1 || rev_pulse !== 1'b0) begin
      errors++; $display("FAIL first_lock: got locked=%b rev_pulse=%b want 1 0", locked, rev_pulse);
    end
    step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    checks++;
    if (rev_pulse !== 1'b1 || rev_count !== 8'd1 || err !== 1'b0) begin
      errors++; $display("FAIL first_rev: got pulse=%b count=%0d err=%b want 1 1 0",
                         rev_pulse, rev_count, err);
    end
    step(1'b1, 3'b010, 1'b0);
    checks++;
    if (rev_pulse !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL rev_pulse_one_cycle: got pulse=%b locked=%b want 0 1",
                         rev_pulse, locked);
    end
  endtask

  task automatic test_skip_error();
    step(1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    step(1'b1, 3'b100, 1'b0);
    checks++;
    if ({err, err_pulse, locked} !== 3'b110 || rev_count !== 8'd2) begin
      errors++; $display("FAIL skip_detect: got err/pulse/locked=%b count=%0d want 110 2",
                         {err, err_pulse, locked}, rev_count);
    end
    step(1'b1, 3'b010, 1'b0);
    checks++;
    if ({err, err_pulse, locked} !== 3'b100) begin
      errors++; $display("FAIL error_hold: got %b want 100", {err, err_pulse, locked});
    end
    step(1'b0, 3'b000, 1'b1);
    checks++;
    if ({err, locked} !== 2'b00) begin
      errors++; $display("FAIL clr_err: got err/locked=%b want 00", {err, locked});
    end
    step(1'b1, 3'b010, 1'b0);
    checks++;
    if (locked !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL relock: got locked=%b err=%b want 1 0", locked, err);
    end
  endtask

  task automatic test_idle_ignore();
    step(1'b1, 3'b000, 1'b0);
    step(1'b0, 3'b000, 1'b1);
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b011, 1'b0);
    checks++;
    if ({err, err_pulse, locked} !== 3'b000) begin
      errors++; $display("FAIL idle_ignore: got err/pulse/locked=%b want 000",
                         {err, err_pulse, locked});
    end
    step(1'b1, 3'b001, 1'b0);
    checks++;
    if (locked !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL idle_lock: got locked=%b err=%b want 1 0", locked, err);
    end
  endtask

  task automatic test_en_gap();
    step(1'b1, 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b111, 1'b0);
      checks++;
      if (locked !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL en_gap_%0d: got locked=%b err=%b want 1 0", i, locked, err);
      end
    end
    step(1'b1, 3'b100, 1'b0);
    checks++;
    if (locked !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL en_resume: got locked=%b err=%b want 1 0", locked, err);
    end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    rst = 1'b1;
    step(1'b0, 3'b000, 1'b0);
    rst = 1'b0;
    step(1'b1, 3'b001, 1'b0);
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 3'b010, 1'b0);
      step(1'b1, 3'b100, 1'b0);
      step(1'b1, 3'b001, 1'b0);
      if (rev_pulse === 1'b1) pulses++;
      if (i == 255) begin
        checks++;
        if (rev_count !== 8'd255) begin
          errors++; $display("FAIL rev_255: got %0d want 255", rev_count);
        end
      end
    end
    checks++;
    if (rev_count !== 8'd0 || rev_pulse !== 1'b1) begin
      errors++; $display("FAIL rev_wrap: got count=%0d pulse=%b want 0 1", rev_count, rev_pulse);
    end
    checks++;
    if (pulses != 256) begin
      errors++; $display("FAIL rev_pulse_total: got %0d want 256", pulses);
    end
  endtask

  task automatic test_clr_mismatch_and_rst();
    step(1'b1, 3'b100, 1'b1);
    checks++;
    if ({err, err_pulse, locked} !== 3'b110) begin
      errors++; $display("FAIL clr_with_mismatch: got %b want 110", {err, err_pulse, locked});
    end
    step(1'b1, 3'b001, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", err);
    end
    step(1'b0, 3'b000, 1'b1);
    step(1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    checks++;
    if (locked !== 1'b1 || rev_count !== 8'd1 || rev_pulse !== 1'b1) begin
      errors++; $display("FAIL pre_rst_rev: got locked=%b count=%0d pulse=%b want 1 1 1",
                         locked, rev_count, rev_pulse);
    end
    rst = 1'b1;
    step(1'b1, 3'b010, 1'b0);
    rst = 1'b0;
    checks++;
    if ({locked, err, err_pulse, rev_pulse} !== 4'b0000 || rev_count !== 8'd0) begin
      errors++; $display("FAIL mid_rst: got flags=%b count=%0d want 0000 0",
                         {locked, err, err_pulse, rev_pulse}, rev_count);
    end
`ifdef RING_MON_ERRCNT_EN
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b001, 1'b0);
      step(1'b1, 3'b001, 1'b0);
      step(1'b0, 3'b000, 1'b1);
    end
    checks++;
    if (err_count !== 8'd3) begin
      errors++; $display("FAIL err_count: got %0d want 3", err_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lock_and_rev();
    test_skip_error();
    test_idle_ignore();
    test_en_gap();
    test_wrap();
    test_clr_mismatch_and_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
